quire_to_posit_4_0: RTL and testbench
=====================================

# quire_to_posit_4_0

Downstream conversion stage for the posit<4,0> dot-product datapath. It consumes the 19-bit two's-complement quire stream from the accumulator, along with its sign, zero and NaR flags. For each end-of-window beat it normalises, rounds to nearest-even and encodes the result as a 4-bit posit. NaR is held sticky across the window, and the rts/rtr handshake runs as a 3-stage pipeline.

## Interface
Parameters:
- LOG_NB_ACCUM, 10, log2 of accumulations per window; QUIRE_SIZE = 9 + LOG_NB_ACCUM (19 at default)
- FRAC_BITS, 4, quire fractional bits (LSB weight 2^-4)

Ports:
- clk  in  1  clock; all flops rising edge
- rst  in  1  reset, asynchronous, active-high
- rtr_o  out  1  ready to receive (combinational, = process_en)
- rts_i  in  1  upstream ready to send
- sow_i, eow_i  in  1 each  start/end of window marker
- data_i  in  QUIRE_SIZE  quire, two's complement, binary point between bits 4 and 3
- sign_i, zero_i, NaR_i  in  1 each  quire flags
- rtr_i  in  1  downstream ready
- rts_o  out  1  output valid
- sow_o, eow_o  out  1 each  markers of emitted beat
- posit_o  out  4  posit<4,0> result
- NaR_o, zero_o  out  1 each  result flags

## Operation
- process_en = rtr_i | ~rts_o; beat accepted when rts_i & process_en.
- Window NaR: at acceptance, win_nar = NaR_i | (nar_acc & ~sow_i); nar_acc <= eow_i ? 0 : win_nar.
- Stage 1: capture data, flags and win_nar. Compute magnitude m = |data_i| as unsigned QUIRE_SIZE bits; -2^18 is representable.
- Stage 2: leading-one position p of m; scale s = p - FRAC_BITS. Bits below the leading one are the fraction.
- Stage 3: encode and round. Bitstring = regime(s) ‖ fraction.
  - Regime by scale: s≥0 → (s+1) ones then a zero; s<0 → (-s) zeros then a one.
  - code = top 3 bits; guard = next bit; sticky = OR of the rest.
  - Increment code if guard & (sticky | code[0]).
- Saturation and sign:
  - s ≥ 2 → code 111 (maxpos 4).
  - Nonzero result with code 000 → 001 (minpos 0.25); a posit never rounds to zero.
  - Negative input: posit_o = two's complement of {0,code}.
- Special results:
  - win_nar → posit_o 1000, NaR_o 1.
  - zero (m==0) → posit_o 0000, zero_o 1.
  - NaR has priority over zero.

## Timing
- Latency: 3 accepted cycles, input beat to rts_o.
- Throughput: one beat per cycle when rtr_i is held high.
- Stall: rts_o high and rtr_i low freezes all stages. rtr_o drops in the same cycle; no beat is lost.
- Bubbles collapse: an empty stage advances while rts_o is low.
- rts_o, posit_o, sow_o, eow_o and the flags stay stable until rtr_i is sampled high.
- sow_i and eow_i on the same beat form a single-beat window; NaR considers only that beat.
- Reset values:
  - All staged bits and nar_acc: 0.
  - rts_o, sow_o, eow_o, NaR_o, zero_o: 0.
  - posit_o: 0000.
- Reset mid-window clears nar_acc and discards in-flight beats.

## Configuration
- QUIRE_TO_POSIT_EOW_FILTER_EN defined:
  - Only eow_i beats enter stage 1.
  - Non-eow beats are accepted (rtr_o honoured) and dropped as bubbles; they still update nar_acc.
- Undefined: every accepted beat is converted and emitted (running result), with win_nar applied per beat.

## Structure
- posit_defines package holds:
  - POSIT_WIDTH=4, ES=0
  - QUIRE_SIZE function of LOG_NB_ACCUM, QUIRE_FRAC_BITS=4
  - POSIT_NAR=4'b1000, POSIT_MAXPOS=4'b0111, POSIT_MINPOS=4'b0001
- Sub-module leading_one_detect: combinational, QUIRE_SIZE-bit input, outputs position p plus a valid (nonzero) flag; registered in stage 2.

## Test plan
- Single-beat window (sow/eow=1), data 48 (3.0) → posit_o 0110 (tie to even, 2.0) after 3 cycles.
- Window ending data 28 (1.75) → 0110. Data 30 (1.875) → 0110. Data 24 (1.5) → 0101.
- Data -16 (-1.0) → 1100. Data 2 (0.125) → 0001. Data 0 → 0000 with zero_o=1. Data 16384 → 0111.
- NaR_i on beat 2 of a 4-beat window, clean final beat → eow result 1000 with NaR_o=1. Next window clean → correct value, NaR_o=0.
- rtr_i low for 5 cycles while streaming 8 windows → no loss or duplication; outputs held stable during stall.
- Assert rst mid-window → outputs zero asynchronously; subsequent window unaffected by prior NaR.

Source files
------------

// File: rtl/quire_to_posit_4_0_pkg.sv
// Shared constants and types for the posit<4,0> quire-to-posit conversion stage.
package posit_defines;

    localparam int POSIT_WIDTH     = 4;
    localparam int ES              = 0;
    localparam int QUIRE_FRAC_BITS = 4;

    localparam logic [POSIT_WIDTH-1:0] POSIT_NAR    = 4'b1000;
    localparam logic [POSIT_WIDTH-1:0] POSIT_MAXPOS = 4'b0111;
    localparam logic [POSIT_WIDTH-1:0] POSIT_MINPOS = 4'b0001;
    localparam logic [POSIT_WIDTH-1:0] POSIT_ZERO   = 4'b0000;

    function automatic int quire_size(input int log_nb_accum);
        return 9 + log_nb_accum;
    endfunction

    // Side-band information travelling with each beat through the pipeline.
    typedef struct packed {
        logic neg;
        logic zero;
        logic nar;
        logic sow;
        logic eow;
    } beat_flags_t;

endpackage

// File: rtl/quire_to_posit_4_0_lod.sv
// Combinational leading-one detector: position of the highest set bit plus a nonzero flag.
module leading_one_detect #(
    parameter int WIDTH = 19,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [POS_W-1:0] pos_o,
    output logic             valid_o
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        pos_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                pos_o   = POS_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// Quire-to-posit<4,0> converter: 3-stage rts/rtr pipeline (magnitude, LOD, encode+RNE) with sticky window NaR.
// Define QUIRE_TO_POSIT_EOW_FILTER_EN to convert only end-of-window beats; other accepted beats become bubbles.
module quire_to_posit_4_0
    import posit_defines::*;
#(
    parameter  int LOG_NB_ACCUM = 10,
    parameter  int FRAC_BITS    = QUIRE_FRAC_BITS,
    localparam int QUIRE_SIZE   = quire_size(LOG_NB_ACCUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rtr_o,
    input  logic                   rts_i,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [QUIRE_SIZE-1:0]  data_i,
    input  logic                   sign_i,
    input  logic                   zero_i,
    input  logic                   NaR_i,
    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [POSIT_WIDTH-1:0] posit_o,
    output logic                   NaR_o,
    output logic                   zero_o
);

    localparam int POS_W = $clog2(QUIRE_SIZE);
    localparam int FW    = FRAC_BITS + 1;   // widest fraction kept below the leading one without saturating
    localparam int BW    = 2 * FW + 2;      // regime plus fraction always fits here

    logic process_en;
    logic accept;
    logic win_nar;

    logic nar_acc_q, nar_acc_d;

    logic                  valid1_q, valid1_d;
    logic [QUIRE_SIZE-1:0] mag1_q, mag1_d;
    beat_flags_t           flags1_q, flags1_d;

    logic             lod_valid;
    logic [POS_W-1:0] lod_pos;

    logic             valid2_q, valid2_d;
    logic [POS_W-1:0] pos2_q, pos2_d;
    logic [FW-1:0]    frac2_q, frac2_d;
    beat_flags_t      flags2_q, flags2_d;

    logic                   valid3_q, valid3_d;
    logic [POSIT_WIDTH-1:0] posit3_q, posit3_d;
    logic                   nar3_q, nar3_d;
    logic                   zero3_q, zero3_d;
    logic                   sow3_q, sow3_d;
    logic                   eow3_q, eow3_d;

    logic                   sat;
    logic [FW-1:0]          frac_al;
    logic [BW-1:0]          bits;
    logic [POS_W-1:0]       r_len;
    logic [2:0]             code;
    logic [2:0]             code_rnd;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [POSIT_WIDTH-1:0] posit_mag;

    // The whole pipeline moves together; it only freezes when a held result is refused.
    assign process_en = rtr_i | ~valid3_q;
    assign accept     = rts_i & process_en;
    assign rtr_o      = process_en;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win_nar   = NaR_i | (nar_acc_q & ~sow_i);
        nar_acc_d = nar_acc_q;
        if (accept) begin
            nar_acc_d = eow_i ? 1'b0 : win_nar;
        end
    end

    // Stage 1: magnitude of the two's-complement quire; -2^(QUIRE_SIZE-1) maps to its unsigned pattern.
    always_comb begin
        valid1_d = valid1_q;
        mag1_d   = mag1_q;
        flags1_d = flags1_q;
        if (process_en) begin
`ifdef QUIRE_TO_POSIT_EOW_FILTER_EN
            valid1_d = accept & eow_i;
`else
            valid1_d = accept;
`endif
            mag1_d   = data_i[QUIRE_SIZE-1] ? (~data_i + 1'b1) : data_i;
            flags1_d = '{neg: sign_i, zero: zero_i, nar: win_nar, sow: sow_i, eow: eow_i};
        end
    end

    leading_one_detect #(
        .WIDTH (QUIRE_SIZE),
        .POS_W (POS_W)
    ) u_lod (
        .vec_i   (mag1_q),
        .pos_o   (lod_pos),
        .valid_o (lod_valid)
    );

    // Stage 2: only the low FW magnitude bits can reach the encoder unsaturated.
    always_comb begin
        valid2_d = valid2_q;
        pos2_d   = pos2_q;
        frac2_d  = frac2_q;
        flags2_d = flags2_q;
        if (process_en) begin
            valid2_d      = valid1_q;
            pos2_d        = lod_pos;
            frac2_d       = mag1_q[FW-1:0];
            flags2_d      = flags1_q;
            flags2_d.zero = flags1_q.zero | ~lod_valid;
        end
    end

    // Stage 3 encoder: bits = regime || fraction, left-aligned; scale s = pos - FRAC_BITS.
    always_comb begin
        sat     = pos2_q >= POS_W'(FRAC_BITS + 2);
        frac_al = '0;
        bits    = '0;
        r_len   = '0;
        if (!sat) begin
            frac_al = frac2_q << (POS_W'(FW) - pos2_q);
            if (pos2_q >= POS_W'(FRAC_BITS)) begin
                r_len = pos2_q - POS_W'(FRAC_BITS) + POS_W'(2);
                bits  = ~({BW{1'b1}} >> (pos2_q - POS_W'(FRAC_BITS) + POS_W'(1)));
            end else begin
                r_len = POS_W'(FRAC_BITS) - pos2_q + POS_W'(1);
                bits  = {1'b1, {(BW-1){1'b0}}} >> (POS_W'(FRAC_BITS) - pos2_q);
            end
            bits = bits | ({frac_al, {(BW-FW){1'b0}}} >> r_len);
        end

        code     = bits[BW-1 -: 3];
        guard    = bits[BW-4];
        sticky   = |bits[BW-5:0];
        round_up = guard & (sticky | code[0]);

        // Rounding past maxpos clips; a nonzero value never rounds down to zero.
        code_rnd = code;
        if (round_up && code != 3'b111) begin
            code_rnd = code + 3'd1;
        end
        if (code_rnd == 3'b000) begin
            code_rnd = POSIT_MINPOS[2:0];
        end
        posit_mag = sat ? POSIT_MAXPOS : {1'b0, code_rnd};
    end

    always_comb begin
        valid3_d = valid3_q;
        posit3_d = posit3_q;
        nar3_d   = nar3_q;
        zero3_d  = zero3_q;
        sow3_d   = sow3_q;
        eow3_d   = eow3_q;
        if (process_en) begin
            valid3_d = valid2_q;
            sow3_d   = flags2_q.sow;
            eow3_d   = flags2_q.eow;
            nar3_d   = flags2_q.nar;
            zero3_d  = ~flags2_q.nar & flags2_q.zero;
            if (flags2_q.nar) begin
                posit3_d = POSIT_NAR;
            end else if (flags2_q.zero) begin
                posit3_d = POSIT_ZERO;
            end else if (flags2_q.neg) begin
                posit3_d = ~posit_mag + 4'd1;
            end else begin
                posit3_d = posit_mag;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nar_acc_q <= 1'b0;
            valid1_q  <= 1'b0;
            mag1_q    <= '0;
            flags1_q  <= '0;
            valid2_q  <= 1'b0;
            pos2_q    <= '0;
            frac2_q   <= '0;
            flags2_q  <= '0;
            valid3_q  <= 1'b0;
            posit3_q  <= POSIT_ZERO;
            nar3_q    <= 1'b0;
            zero3_q   <= 1'b0;
            sow3_q    <= 1'b0;
            eow3_q    <= 1'b0;
        end else begin
            nar_acc_q <= nar_acc_d;
            valid1_q  <= valid1_d;
            mag1_q    <= mag1_d;
            flags1_q  <= flags1_d;
            valid2_q  <= valid2_d;
            pos2_q    <= pos2_d;
            frac2_q   <= frac2_d;
            flags2_q  <= flags2_d;
            valid3_q  <= valid3_d;
            posit3_q  <= posit3_d;
            nar3_q    <= nar3_d;
            zero3_q   <= zero3_d;
            sow3_q    <= sow3_d;
            eow3_q    <= eow3_d;
        end
    end

    assign rts_o   = valid3_q;
    assign posit_o = posit3_q;
    assign NaR_o   = nar3_q;
    assign zero_o  = zero3_q;
    assign sow_o   = sow3_q;
    assign eow_o   = eow3_q;

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Directed bench for quire_to_posit_4_0: table of single-beat windows plus NaR, stall and reset sequences.
module tb_quire_to_posit_4_0;

    localparam int QS = 19;
`ifdef QUIRE_TO_POSIT_EOW_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] posit;
        logic       nar;
        logic       zero;
        logic       sow;
        logic       eow;
    } out_t;

    typedef struct {
        logic signed [QS-1:0] data;
        logic                 nar_in;
        logic [3:0]           exp_posit;
        logic                 exp_nar;
        logic                 exp_zero;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rtr_o;
    logic                 rts_i = 1'b0;
    logic                 sow_i = 1'b0;
    logic                 eow_i = 1'b0;
    logic signed [QS-1:0] data_i = '0;
    logic                 sign_i = 1'b0;
    logic                 zero_i = 1'b0;
    logic                 nar_i = 1'b0;
    logic                 rtr_i = 1'b1;
    logic                 rts_o;
    logic                 sow_o;
    logic                 eow_o;
    logic [3:0]           posit_o;
    logic                 nar_o;
    logic                 zero_o;

    int n_checks = 0;
    int n_pass   = 0;

    out_t exp_q[$];
    out_t got_q[$];
    vec_t vecs[16];

    logic stalled_prev = 1'b0;
    out_t held;

    quire_to_posit_4_0 dut (
        .clk     (clk),
        .rst     (rst),
        .rtr_o   (rtr_o),
        .rts_i   (rts_i),
        .sow_i   (sow_i),
        .eow_i   (eow_i),
        .data_i  (data_i),
        .sign_i  (sign_i),
        .zero_i  (zero_i),
        .NaR_i   (nar_i),
        .rtr_i   (rtr_i),
        .rts_o   (rts_o),
        .sow_o   (sow_o),
        .eow_o   (eow_o),
        .posit_o (posit_o),
        .NaR_o   (nar_o),
        .zero_o  (zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Collect transfers and verify held outputs during stalls.
    always @(negedge clk) begin
        out_t cur;
        cur = '{posit: posit_o, nar: nar_o, zero: zero_o, sow: sow_o, eow: eow_o};
        if (!rst && rts_o && rtr_i) got_q.push_back(cur);
        if (!rst && rts_o && !rtr_i) begin
            check("stall_rtr_o_low", 32'(rtr_o), 32'd0);
            if (stalled_prev) check("stall_hold", 32'(cur), 32'(held));
            stalled_prev = 1'b1;
            held         = cur;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic send(input logic signed [QS-1:0] data, input logic sow, input logic eow,
                        input logic nar, input logic [3:0] ep, input logic en, input logic ez);
        int waited;
        rts_i  = 1'b1;
        data_i = data;
        sign_i = data < 0;
        zero_i = data == 0;
        sow_i  = sow;
        eow_i  = eow;
        nar_i  = nar;
        waited = 0;
        forever begin
            @(negedge clk);
            if (rtr_o) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                $display("FAIL send_timeout: rtr_o stayed low for %0d cycles", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        rts_i = 1'b0;
        nar_i = 1'b0;
        if (eow || !FILTER_EN) exp_q.push_back('{posit: ep, nar: en, zero: ez, sow: sow, eow: eow});
    endtask

    task automatic drain_and_compare(input string tag);
        int waited;
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            end else begin
                n_checks++;
                $display("FAIL %s_beat%0d: missing, expected %0h", tag, i, exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{19'sd48,     1'b0, 4'b0110, 1'b0, 1'b0};  // 3.0 ties to even 2.0
        vecs[1]  = '{19'sd28,     1'b0, 4'b0110, 1'b0, 1'b0};  // 1.75
        vecs[2]  = '{19'sd30,     1'b0, 4'b0110, 1'b0, 1'b0};  // 1.875
        vecs[3]  = '{19'sd24,     1'b0, 4'b0101, 1'b0, 1'b0};  // 1.5
        vecs[4]  = '{-19'sd16,    1'b0, 4'b1100, 1'b0, 1'b0};  // -1.0
        vecs[5]  = '{19'sd2,      1'b0, 4'b0001, 1'b0, 1'b0};  // 0.125 -> minpos
        vecs[6]  = '{19'sd0,      1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[7]  = '{19'sd16384,  1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[8]  = '{-19'sd262144, 1'b0, 4'b1001, 1'b0, 1'b0}; // most negative quire -> -maxpos
        vecs[9]  = '{19'sd60,     1'b0, 4'b0111, 1'b0, 1'b0};  // 3.75 rounds to maxpos
        vecs[10] = '{19'sd3,      1'b0, 4'b0001, 1'b0, 1'b0};  // 0.1875
        vecs[11] = '{-19'sd24,    1'b0, 4'b1011, 1'b0, 1'b0};  // -1.5
        vecs[12] = '{19'sd20,     1'b0, 4'b0100, 1'b0, 1'b0};  // 1.25 ties to even 1.0
        vecs[13] = '{19'sd40,     1'b0, 4'b0110, 1'b0, 1'b0};  // 2.5
        vecs[14] = '{19'sd12,     1'b0, 4'b0011, 1'b0, 1'b0};  // 0.75
        vecs[15] = '{19'sd0,      1'b1, 4'b1000, 1'b1, 1'b0};  // NaR beats zero

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rts_o", 32'(rts_o), 32'd0);
        check("reset_outputs", 32'({posit_o, nar_o, zero_o, sow_o, eow_o}), 32'd0);
        check("reset_rtr_o", 32'(rtr_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table of single-beat windows, streamed back to back
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].data, 1'b1, 1'b1, vecs[i].nar_in, vecs[i].exp_posit, vecs[i].exp_nar, vecs[i].exp_zero);
        end
        drain_and_compare("table");

        // Sticky NaR inside a 4-beat window, then a clean window
        send(19'sd16, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        send(19'sd16, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
        send(19'sd8,  1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
        send(19'sd28, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0);
        send(19'sd8,  1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
        send(19'sd24, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);
        drain_and_compare("nar_window");

        // Eight 2-beat windows with rtr_i low for 5 cycles in the middle
        fork
            begin
                for (int w = 0; w < 8; w++) begin
                    send(19'sd8, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
                    send(vecs[w].data, 1'b0, 1'b1, 1'b0, vecs[w].exp_posit, vecs[w].exp_nar, vecs[w].exp_zero);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 rtr_i = 1'b0;
                repeat (5) @(posedge clk);
                #1 rtr_i = 1'b1;
            end
        join
        drain_and_compare("stall");

        // Reset mid-window: NaR pending in nar_acc and beats in flight
        send(19'sd16, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
        send(19'sd8,  1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rts_o", 32'(rts_o), 32'd0);
        check("async_rst_outputs", 32'({posit_o, nar_o, zero_o, sow_o, eow_o}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        // Continuation beat without sow: a surviving nar_acc would turn it into NaR
        send(19'sd16, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
        drain_and_compare("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
